// File: rtl/dcache_sa_ctrl_if.sv
// CPU-side and line-memory-side signal bundle for dcache_sa_ctrl.
// slave: cache controller view, master: pipeline/memory environment view.
interface dcache_sa_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LINE_W = 256
);
  logic [ADDR_W-1:0] p1_addr_i;
  logic [DATA_W-1:0] p1_data_i;
  logic              p1_MemRead_i;
  logic              p1_MemWrite_i;
  logic [DATA_W-1:0] p1_data_o;
  logic              p1_stall_o;
  logic [LINE_W-1:0] mem_data_i;
  logic              mem_ack_i;
  logic [LINE_W-1:0] mem_data_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_enable_o;
  logic              mem_write_o;

  modport slave (
    input  p1_addr_i, p1_data_i,
    input  p1_MemRead_i, p1_MemWrite_i,
    input  mem_data_i, mem_ack_i,
    output p1_data_o, p1_stall_o,
    output mem_data_o, mem_addr_o,
    output mem_enable_o, mem_write_o
  );

  modport master (
    output p1_addr_i, p1_data_i,
    output p1_MemRead_i, p1_MemWrite_i,
    output mem_data_i, mem_ack_i,
    input  p1_data_o, p1_stall_o,
    input  mem_data_o, mem_addr_o,
    input  mem_enable_o, mem_write_o
  );
endinterface

// File: rtl/dcache_sa_ctrl.sv
// Set-associative write-back write-allocate data cache controller.
// Define DCACHE_STATS_EN to add saturating hit/miss counters.
module dcache_sa_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LINE_W = 256,
  parameter int SETS   = 16,
  parameter int WAYS   = 2
) (
  input logic clk_i,
  input logic rst_i,
  dcache_sa_ctrl_if.slave bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] stat_hit_o,
  output logic [31:0] stat_miss_o
`endif
);

  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int WSEL_W = OFF_W - 2;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WB,
    REFILL
  } state_t;

  state_t state_q;

  logic [TAG_W-1:0]  tag_arr  [SETS][WAYS];
  logic [LINE_W-1:0] data_arr [SETS][WAYS];
  logic [WAYS-1:0]   valid_q  [SETS];
  logic [WAYS-1:0]   dirty_q  [SETS];
  logic [WAY_W-1:0]  rr_q     [SETS];

  logic [WAY_W-1:0]  vic_q;
  logic              mem_en_q;
  logic              mem_wr_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              reeval_q;

  logic [WSEL_W-1:0] off;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;

  assign off = bus.p1_addr_i[OFF_W-1:2];
  assign idx = bus.p1_addr_i[OFF_W+IDX_W-1:OFF_W];
  assign tag = bus.p1_addr_i[ADDR_W-1:OFF_W+IDX_W];

  logic req;
  logic wr;
  logic idle;

  assign req  = bus.p1_MemRead_i | bus.p1_MemWrite_i;
  assign wr   = bus.p1_MemWrite_i;
  assign idle = (state_q == IDLE);

  logic             hit;
  logic [WAY_W-1:0] hit_way;

  // Tag lookup across all ways of the addressed set
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx][w] && tag_arr[idx][w] == tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  logic [WAY_W-1:0] vic;
  logic             vic_free;

  // Victim: first invalid way, otherwise the set's round-robin way
  always_comb begin
    vic      = rr_q[idx];
    vic_free = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!vic_free && !valid_q[idx][w]) begin
        vic      = WAY_W'(w);
        vic_free = 1'b1;
      end
    end
  end

  logic [LINE_W-1:0] hit_line;
  logic [DATA_W-1:0] hit_word;

  assign hit_line = data_arr[idx][hit_way];
  assign hit_word = hit_line[{off, 5'd0} +: DATA_W];

  logic miss_start;
  logic wr_hit;
  logic fill;
  logic vic_wb;

  assign miss_start = idle & req & ~hit;
  assign wr_hit     = idle & wr & hit;
  assign fill       = (state_q == REFILL) & bus.mem_ack_i;
  assign vic_wb     = valid_q[idx][vic] & dirty_q[idx][vic];

  // Miss-handling FSM with registered memory request outputs
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      vic_q      <= '0;
      mem_en_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_addr_q <= '0;
      reeval_q   <= 1'b0;
    end else begin
      reeval_q <= fill;
      unique case (state_q)
        IDLE: begin
          if (miss_start) begin
            vic_q    <= vic;
            mem_en_q <= 1'b1;
            if (vic_wb) begin
              state_q    <= WB;
              mem_wr_q   <= 1'b1;
              mem_addr_q <= {tag_arr[idx][vic], idx, {OFF_W{1'b0}}};
            end else begin
              state_q    <= REFILL;
              mem_wr_q   <= 1'b0;
              mem_addr_q <= {tag, idx, {OFF_W{1'b0}}};
            end
          end
        end
        WB: begin
          if (bus.mem_ack_i) begin
            state_q    <= REFILL;
            mem_wr_q   <= 1'b0;
            mem_addr_q <= {tag, idx, {OFF_W{1'b0}}};
          end
        end
        REFILL: begin
          if (bus.mem_ack_i) begin
            state_q    <= IDLE;
            mem_en_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_addr_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Valid, dirty and round-robin bookkeeping
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else if (wr_hit) begin
      dirty_q[idx][hit_way] <= 1'b1;
    end else if (fill) begin
      valid_q[idx][vic_q] <= 1'b1;
      dirty_q[idx][vic_q] <= 1'b0;
      if (WAYS > 1 && valid_q[idx][vic_q]) begin
        rr_q[idx] <= (rr_q[idx] == WAY_W'(WAYS - 1))
                   ? '0 : rr_q[idx] + 1'b1;
      end
    end
  end

  // Tag and line storage, left uninitialised by reset
  always_ff @(posedge clk_i) begin
    if (wr_hit) begin
      data_arr[idx][hit_way][{off, 5'd0} +: DATA_W] <= bus.p1_data_i;
    end else if (fill) begin
      data_arr[idx][vic_q] <= bus.mem_data_i;
      tag_arr[idx][vic_q]  <= tag;
    end
  end

  assign bus.p1_stall_o   = rst_i & (~idle | (req & ~hit));
  assign bus.p1_data_o    = (rst_i && idle && hit) ? hit_word : '0;
  assign bus.mem_enable_o = rst_i & mem_en_q;
  assign bus.mem_write_o  = rst_i & mem_wr_q;
  assign bus.mem_addr_o   = rst_i ? mem_addr_q : '0;
  assign bus.mem_data_o   = (rst_i && state_q == WB)
                          ? data_arr[idx][vic_q] : '0;

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  // First-evaluation hits and miss entries, saturating
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (idle && req && hit && !reeval_q && hit_cnt_q != '1) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (miss_start && miss_cnt_q != '1) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign stat_hit_o  = rst_i ? hit_cnt_q : '0;
  assign stat_miss_o = rst_i ? miss_cnt_q : '0;
`endif

endmodule

// File: tb/tb_dcache_sa_ctrl.sv
// Bench for dcache_sa_ctrl: directed scenarios plus random traffic
// checked against a set/way replacement model and a flat word memory.
module tb_dcache_sa_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dcache_sa_ctrl_if bus ();

`ifdef DCACHE_STATS_EN
  logic [31:0] stat_hit;
  logic [31:0] stat_miss;
`endif

  dcache_sa_ctrl dut (
    .clk_i(clk),
    .rst_i(rst_n),
    .bus  (bus)
`ifdef DCACHE_STATS_EN
    ,
    .stat_hit_o (stat_hit),
    .stat_miss_o(stat_miss)
`endif
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] data;
  } txn_t;

  txn_t txn_q[$];
  logic [255:0] back[bit [31:0]];
  bit [31:0] truth[bit [31:0]];
  int ack_delay = 0;

  bit [22:0] mtag[16][2];
  bit mval[16][2];
  bit mdirty[16][2];
  int mrr[16];
  int n_hit = 0;
  int n_miss = 0;

  function automatic bit [31:0] init_word(bit [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [255:0] get_line(bit [31:0] la);
    logic [255:0] l;
    if (back.exists(la)) return back[la];
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = init_word(la + w * 4);
    return l;
  endfunction

  function automatic bit [31:0] exp_word(bit [31:0] a);
    if (truth.exists(a)) return truth[a];
    return init_word(a);
  endfunction

  task automatic preload(bit [31:0] a, bit [31:0] v);
    logic [255:0] l;
    bit [31:0] la;
    la = a & ~32'h1F;
    l = get_line(la);
    l[int'(a[4:2])*32 +: 32] = v;
    back[la] = l;
    truth[a] = v;
  endtask

  // Dirty lines are lost on reset: the memory copy becomes the truth.
  task automatic model_reset();
    bit [31:0] la;
    logic [255:0] l;
    for (int s = 0; s < 16; s++) begin
      for (int w = 0; w < 2; w++) begin
        if (mval[s][w] && mdirty[s][w]) begin
          la = {mtag[s][w], 4'(s), 5'b0};
          l = get_line(la);
          for (int k = 0; k < 8; k++) truth[la + k * 4] = l[k*32 +: 32];
        end
        mval[s][w] = 0;
        mdirty[s][w] = 0;
      end
      mrr[s] = 0;
    end
    n_hit = 0;
    n_miss = 0;
  endtask

  // Line memory: acks after ack_delay enabled cycles
  initial begin
    int cnt;
    txn_t t;
    cnt = 0;
    bus.mem_ack_i = 1'b0;
    bus.mem_data_i = '0;
    forever begin
      @(negedge clk);
      bus.mem_ack_i = 1'b0;
      if (rst_n && bus.mem_enable_o) begin
        if (cnt >= ack_delay) begin
          t.wr = bus.mem_write_o;
          t.addr = bus.mem_addr_o;
          t.data = bus.mem_data_o;
          txn_q.push_back(t);
          if (t.wr) back[t.addr] = t.data;
          else bus.mem_data_i = get_line(t.addr);
          bus.mem_ack_i = 1'b1;
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic do_access(input bit wr, input bit [31:0] a,
                           input bit [31:0] d, input string nm);
    bit [3:0] idx;
    bit [22:0] tg;
    int hw, vic, ntx, cyc, en_bad, exp_cyc;
    bit exp_wb, first_stall;
    bit [31:0] wb_addr, rf_addr, ew, rdata;
    idx = a[8:5];
    tg = a[31:9];
    hw = -1;
    for (int w = 0; w < 2; w++)
      if (mval[idx][w] && mtag[idx][w] == tg) hw = w;
    vic = -1;
    exp_wb = 0;
    if (hw < 0) begin
      for (int w = 0; w < 2; w++)
        if (vic < 0 && !mval[idx][w]) vic = w;
      if (vic < 0) vic = mrr[idx];
      exp_wb = mval[idx][vic] && mdirty[idx][vic];
    end
    wb_addr = {mtag[idx][vic < 0 ? 0 : vic], idx, 5'b0};
    rf_addr = {tg, idx, 5'b0};
    ntx = (hw >= 0) ? 0 : (exp_wb ? 2 : 1);
    exp_cyc = (hw >= 0) ? 0 : ntx * (ack_delay + 1) + 1;
    ew = exp_word(a & ~32'h3);
    txn_q.delete();

    @(negedge clk);
    bus.p1_addr_i = a;
    bus.p1_data_i = d;
    bus.p1_MemWrite_i = wr;
    bus.p1_MemRead_i = ~wr;
    #1;
    first_stall = bus.p1_stall_o;
    cyc = 0;
    en_bad = 0;
    while (bus.p1_stall_o && cyc < 300) begin
      @(negedge clk);
      #1;
      cyc++;
      if (bus.p1_stall_o && !bus.mem_enable_o) en_bad++;
    end
    rdata = bus.p1_data_o;

    checks++;
    if (first_stall !== (hw < 0)) begin
      failures++;
      $display("FAIL %s first_stall got=%0b exp=%0b", nm, first_stall, hw < 0);
    end
    checks++;
    if (cyc !== exp_cyc) begin
      failures++;
      $display("FAIL %s stall_cycles got=%0d exp=%0d", nm, cyc, exp_cyc);
    end
    checks++;
    if (en_bad !== 0) begin
      failures++;
      $display("FAIL %s enable_low_while_stalled got=%0d exp=0", nm, en_bad);
    end
    checks++;
    if (txn_q.size() !== ntx) begin
      failures++;
      $display("FAIL %s txn_count got=%0d exp=%0d", nm, txn_q.size(), ntx);
    end else if (ntx > 0) begin
      checks++;
      if (exp_wb && (txn_q[0].wr !== 1'b1 || txn_q[0].addr !== wb_addr)) begin
        failures++;
        $display("FAIL %s wb got=%0b/%h exp=1/%h", nm,
                 txn_q[0].wr, txn_q[0].addr, wb_addr);
      end
      checks++;
      if (txn_q[ntx-1].wr !== 1'b0 || txn_q[ntx-1].addr !== rf_addr) begin
        failures++;
        $display("FAIL %s refill got=%0b/%h exp=0/%h", nm,
                 txn_q[ntx-1].wr, txn_q[ntx-1].addr, rf_addr);
      end
    end
    if (!wr) begin
      checks++;
      if (rdata !== ew) begin
        failures++;
        $display("FAIL %s rdata got=%h exp=%h", nm, rdata, ew);
      end
    end

    @(negedge clk);
    bus.p1_MemRead_i = 1'b0;
    bus.p1_MemWrite_i = 1'b0;

    if (hw < 0) begin
      n_miss++;
      if (mval[idx][vic]) mrr[idx] = (mrr[idx] + 1) % 2;
      mtag[idx][vic] = tg;
      mval[idx][vic] = 1;
      mdirty[idx][vic] = 0;
      hw = vic;
    end else begin
      n_hit++;
    end
    if (wr) begin
      mdirty[idx][hw] = 1;
      truth[a & ~32'h3] = d;
    end
  endtask

  task automatic test_reset();
    bus.p1_addr_i = 32'h40;
    bus.p1_data_i = '0;
    bus.p1_MemRead_i = 1'b1;
    bus.p1_MemWrite_i = 1'b0;
    #3;
    checks++;
    if ({bus.p1_stall_o, bus.mem_enable_o, bus.mem_write_o} !== 3'b000 ||
        bus.p1_data_o !== '0 || bus.mem_addr_o !== '0 ||
        bus.mem_data_o !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%0b%0b%0b %h %h exp=000 0 0",
               bus.p1_stall_o, bus.mem_enable_o, bus.mem_write_o,
               bus.p1_data_o, bus.mem_addr_o);
    end
    repeat (2) @(negedge clk);
    bus.p1_MemRead_i = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.p1_stall_o !== 1'b0 || bus.mem_enable_o !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_req got=%0b%0b exp=00",
               bus.p1_stall_o, bus.mem_enable_o);
    end
  endtask

  task automatic test_cold_read();
    preload(32'h44, 32'h1111_1111);
    do_access(0, 32'h44, 0, "cold_read");
  endtask

  task automatic test_write_hit();
    do_access(1, 32'h44, 32'hDEAD_BEEF, "write_hit");
    do_access(0, 32'h44, 0, "read_after_write");
  endtask

  task automatic test_evict();
    do_access(0, 32'h240, 0, "fill_way1");
    do_access(0, 32'h440, 0, "evict_way0");
    checks++;
    if (txn_q.size() < 1 || txn_q[0].data[63:32] !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL wb_data got=%h exp=deadbeef",
               txn_q.size() ? txn_q[0].data[63:32] : 32'h0);
    end
    do_access(0, 32'h44, 0, "reload_written_back");
  endtask

`ifdef DCACHE_STATS_EN
  task automatic test_stats();
    checks++;
    if (stat_miss !== 32'd4 || stat_hit !== 32'd2) begin
      failures++;
      $display("FAIL stats_directed got=%0d/%0d exp=4/2",
               stat_miss, stat_hit);
    end
  endtask
`endif

  task automatic test_slow_ack();
    ack_delay = 10;
    do_access(0, 32'h0860, 0, "slow_ack");
    ack_delay = 0;
  endtask

  task automatic test_reset_mid_refill();
    @(negedge clk);
    ack_delay = 20;
    bus.p1_addr_i = 32'h1000;
    bus.p1_MemRead_i = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (bus.mem_enable_o !== 1'b1 || bus.p1_stall_o !== 1'b1) begin
      failures++;
      $display("FAIL pre_abort got=%0b%0b exp=11",
               bus.mem_enable_o, bus.p1_stall_o);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.mem_enable_o !== 1'b0 || bus.p1_stall_o !== 1'b0) begin
      failures++;
      $display("FAIL abort got=%0b%0b exp=00",
               bus.mem_enable_o, bus.p1_stall_o);
    end
    @(negedge clk);
    bus.p1_MemRead_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    ack_delay = 0;
    do_access(0, 32'h1000, 0, "miss_after_abort");
    do_access(0, 32'h44, 0, "dirty_lost_on_reset");
  endtask

  task automatic test_random();
    bit [31:0] a;
    for (int i = 0; i < 250; i++) begin
      a = {21'($urandom_range(0, 3)), 2'b0, 4'($urandom_range(0, 3)),
           3'($urandom_range(0, 7)), 2'b0};
      ack_delay = $urandom_range(0, 3);
      do_access(1'($urandom_range(0, 1)), a, $urandom, "random");
    end
    ack_delay = 0;
  endtask

  initial begin
    bus.p1_addr_i = '0;
    bus.p1_data_i = '0;
    bus.p1_MemRead_i = 1'b0;
    bus.p1_MemWrite_i = 1'b0;
    model_reset();
    test_reset();
    test_cold_read();
    test_write_hit();
    test_evict();
`ifdef DCACHE_STATS_EN
    test_stats();
`endif
    test_slow_ack();
    test_reset_mid_refill();
    test_random();
`ifdef DCACHE_STATS_EN
    #1;
    checks++;
    if (stat_hit !== n_hit || stat_miss !== n_miss) begin
      failures++;
      $display("FAIL stats_random got=%0d/%0d exp=%0d/%0d",
               stat_hit, stat_miss, n_hit, n_miss);
    end
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
